// File: rtl/dsky_serial_decoder_pkg.sv
// Shared types, widths and default byte codes for the DSKY serial frame decoder.
package dsky_serial_decoder_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DATA_W    = 15;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned REG_COUNT = 5;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [BYTE_W-1:0] ACK_BYTE_DEFAULT  = 8'h06;
  localparam logic [BYTE_W-1:0] NAK_BYTE_DEFAULT  = 8'h15;

  typedef enum logic [SEL_W-1:0] {
    VERB         = 3'd0,
    NOUN         = 3'd1,
    MISSION_TIME = 3'd2,
    APOGEE       = 3'd3,
    PERIGEE      = 3'd4
  } dsky_reg_id_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID      = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    RESPOND = 3'd5
  } dsky_frame_state_t;

  // Bytes of a frame latched ahead of the checksum byte.
  typedef struct packed {
    logic [BYTE_W-1:0] id;
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } dsky_frame_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dsky_serial_decoder_frame_timeout_timer.sv
// Inter-byte idle timer: expired_c rises once TIMEOUT_CYCLES-1 enabled idle cycles have elapsed.
module frame_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  logic [CNT_W-1:0] count_q;

  assign expired_c = enable && (count_q == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired_c) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dsky_serial_decoder.sv
// Frames UART bytes into 5-byte register write packets, updates the DSKY registers
// and answers every completed frame with ACK or NAK.
module dsky_serial_decoder
  import dsky_serial_decoder_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT,
  parameter logic [7:0]  NAK_BYTE       = NAK_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [BYTE_W-1:0] tx_byte,
  output logic [DATA_W-1:0] verb_data,
  output logic [DATA_W-1:0] noun_data,
  output logic [DATA_W-1:0] mission_time_data,
  output logic [DATA_W-1:0] apogee_data,
  output logic [DATA_W-1:0] perigee_data,
  output logic              update_valid,
  output logic [SEL_W-1:0]  update_sel,
  output logic [7:0]        frame_err_count
);

  dsky_frame_state_t state_q, state_d;
  dsky_frame_t       frame_q, frame_d;
  logic [DATA_W-1:0] regs_q [REG_COUNT];
  logic [DATA_W-1:0] regs_d [REG_COUNT];
  logic              tx_valid_d, update_valid_d;
  logic [BYTE_W-1:0] tx_byte_d;
  logic [SEL_W-1:0]  update_sel_d;
  logic [7:0]        err_d;

  logic in_frame_c, frame_ok_c;
  logic timer_clear_c, timer_enable_c, timer_expired_c;

  assign verb_data         = regs_q[0];
  assign noun_data         = regs_q[1];
  assign mission_time_data = regs_q[2];
  assign apogee_data       = regs_q[3];
  assign perigee_data      = regs_q[4];

  // Timer runs only between frame bytes; idle and respond phases hold it cleared.
  assign in_frame_c     = state_q inside {ID, DATA_HI, DATA_LO, CHECK};
  assign timer_clear_c  = rx_valid || !in_frame_c;
  assign timer_enable_c = in_frame_c && !rx_valid;

  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (timer_clear_c),
    .enable    (timer_enable_c),
    .expired_c (timer_expired_c)
  );

  assign frame_ok_c = ((frame_q.id ^ frame_q.hi ^ frame_q.lo) == rx_byte) &&
                      (frame_q.id <= 8'(PERIGEE)) && !frame_q.hi[7];

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    regs_d         = regs_q;
    tx_valid_d     = tx_valid;
    tx_byte_d      = tx_byte;
    update_valid_d = 1'b0;
    update_sel_d   = update_sel;
    err_d          = frame_err_count;

    if (timer_expired_c) begin
      state_d = IDLE;
      err_d   = sat_inc8(frame_err_count);
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_valid && (rx_byte == SYNC_BYTE)) state_d = ID;
        end
        ID: begin
          if (rx_valid) begin
            frame_d.id = rx_byte;
            state_d    = DATA_HI;
          end
        end
        DATA_HI: begin
          if (rx_valid) begin
            frame_d.hi = rx_byte;
            state_d    = DATA_LO;
          end
        end
        DATA_LO: begin
          if (rx_valid) begin
            frame_d.lo = rx_byte;
            state_d    = CHECK;
          end
        end
        CHECK: begin
          if (rx_valid) begin
            tx_valid_d = 1'b1;
            state_d    = RESPOND;
            if (frame_ok_c) begin
              for (int unsigned i = 0; i < REG_COUNT; i++) begin
                if (frame_q.id == 8'(i)) regs_d[i] = {frame_q.hi[6:0], frame_q.lo};
              end
              update_valid_d = 1'b1;
              update_sel_d   = SEL_W'(frame_q.id);
              tx_byte_d      = ACK_BYTE;
            end else begin
              tx_byte_d = NAK_BYTE;
              err_d     = sat_inc8(frame_err_count);
            end
          end
        end
        RESPOND: begin
          if (rx_valid) err_d = sat_inc8(frame_err_count);
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      frame_q         <= '0;
      tx_valid        <= 1'b0;
      tx_byte         <= '0;
      update_valid    <= 1'b0;
      update_sel      <= '0;
      frame_err_count <= '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      frame_q         <= frame_d;
      tx_valid        <= tx_valid_d;
      tx_byte         <= tx_byte_d;
      update_valid    <= update_valid_d;
      update_sel      <= update_sel_d;
      frame_err_count <= err_d;
      regs_q          <= regs_d;
    end
  end

endmodule

// File: tb/tb_dsky_serial_decoder.sv
// Self-checking bench for dsky_serial_decoder: table vectors, directed corner sequences
// and randomized traffic compared cycle by cycle against a byte-queue reference model.
module tb_dsky_serial_decoder;

  localparam int unsigned TO = 64;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clock, reset_n, rx_valid, tx_ready, tx_valid, update_valid;
  logic [7:0]  rx_byte, tx_byte, frame_err_count;
  logic [14:0] verb_data, noun_data, mission_time_data, apogee_data, perigee_data;
  logic [2:0]  update_sel;

  int checks = 0;
  int failures = 0;

  dsky_serial_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .verb_data(verb_data), .noun_data(noun_data), .mission_time_data(mission_time_data),
    .apogee_data(apogee_data), .perigee_data(perigee_data),
    .update_valid(update_valid), .update_sel(update_sel), .frame_err_count(frame_err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: bytes collected so far in the current frame plus response state.
  logic [7:0]  fbuf[$];
  int          gap;
  bit          m_pending;
  logic [7:0]  m_resp;
  logic [14:0] m_regs [5];
  int          m_err;
  bit          m_upd;
  int          m_sel;

  typedef struct {
    logic [39:0] frame;
    logic [7:0]  resp;
    bit          upd;
    logic [2:0]  sel;
    logic [14:0] val;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] dut_reg(input int i);
    case (i)
      0: return verb_data;
      1: return noun_data;
      2: return mission_time_data;
      3: return apogee_data;
      4: return perigee_data;
      default: return 15'h0;
    endcase
  endfunction

  task automatic model_reset();
    fbuf.delete();
    gap = 0; m_pending = 0; m_resp = 8'h00; m_err = 0; m_upd = 0; m_sel = 0;
    for (int i = 0; i < 5; i++) m_regs[i] = 15'h0;
  endtask

  task automatic err_inc();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input bit rv, input logic [7:0] rb, input bit tr);
    int id, hi, lo, chk;
    m_upd = 0;
    if (m_pending) begin
      if (rv) err_inc();
      if (tr) m_pending = 0;
    end else if (fbuf.size() == 0) begin
      if (rv && rb == 8'hA5) begin
        fbuf.push_back(rb);
        gap = 0;
      end
    end else if (rv) begin
      gap = 0;
      fbuf.push_back(rb);
      if (fbuf.size() == 5) begin
        id = int'(fbuf[1]); hi = int'(fbuf[2]); lo = int'(fbuf[3]); chk = int'(fbuf[4]);
        if (chk == (id ^ hi ^ lo) && id < 5 && hi < 128) begin
          m_regs[id] = 15'((hi % 128) * 256 + lo);
          m_upd = 1; m_sel = id; m_resp = ACK;
        end else begin
          err_inc(); m_resp = NAK;
        end
        m_pending = 1;
        fbuf.delete();
      end
    end else begin
      gap++;
      if (gap == TO) begin
        fbuf.delete();
        err_inc();
      end
    end
  endtask

  task automatic compare_all();
    check("tx_valid", 32'(tx_valid), 32'(m_pending));
    if (m_pending) check("tx_byte", 32'(tx_byte), 32'(m_resp));
    check("update_valid", 32'(update_valid), 32'(m_upd));
    if (m_upd) check("update_sel", 32'(update_sel), 32'(m_sel));
    for (int i = 0; i < 5; i++) check($sformatf("reg%0d", i), 32'(dut_reg(i)), 32'(m_regs[i]));
    check("frame_err_count", 32'(frame_err_count), 32'(m_err));
  endtask

  task automatic cycle(input bit rv, input logic [7:0] rb, input bit tr);
    rx_valid = rv; rx_byte = rb; tx_ready = tr;
    @(posedge clock);
    model_step(rv, rb, tr);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [39:0] f);
    for (int i = 0; i < 5; i++) cycle(1'b1, f[39-8*i -: 8], 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_tx_byte"}, 32'(tx_byte), 0);
    check({tag, "_update_valid"}, 32'(update_valid), 0);
    check({tag, "_update_sel"}, 32'(update_sel), 0);
    check({tag, "_err"}, 32'(frame_err_count), 0);
    for (int i = 0; i < 5; i++) check($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 0);
  endtask

  initial begin
    int e0;
    int q[$];
    int kind, id, hi, lo, chk, b;
    bit tr;

    vecs[0] = '{40'hA5_00_00_25_25, ACK, 1, 3'd0, 15'h0025};
    vecs[1] = '{40'hA5_04_7F_FF_84, ACK, 1, 3'd4, 15'h7FFF};
    vecs[2] = '{40'hA5_01_00_10_12, NAK, 0, 3'd1, 15'h0000};
    vecs[3] = '{40'hA5_07_00_01_06, NAK, 0, 3'd7, 15'h0000};
    vecs[4] = '{40'hA5_02_80_00_82, NAK, 0, 3'd2, 15'h0000};
    vecs[5] = '{40'hA5_02_12_34_24, ACK, 1, 3'd2, 15'h1234};

    reset_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
    model_reset();
    #3 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    // Garbage ahead of a frame is discarded with no error.
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    check("garbage_err", 32'(frame_err_count), 0);

    for (int i = 0; i < 6; i++) begin
      e0 = int'(frame_err_count);
      send_frame(vecs[i].frame);
      check($sformatf("vec%0d_tx_valid", i), 32'(tx_valid), 1);
      check($sformatf("vec%0d_resp", i), 32'(tx_byte), 32'(vecs[i].resp));
      check($sformatf("vec%0d_upd", i), 32'(update_valid), 32'(vecs[i].upd));
      if (vecs[i].upd) begin
        check($sformatf("vec%0d_sel", i), 32'(update_sel), 32'(vecs[i].sel));
        check($sformatf("vec%0d_val", i), 32'(dut_reg(int'(vecs[i].sel))), 32'(vecs[i].val));
      end
      cycle(1'b0, 8'h00, 1'b0);
      check($sformatf("vec%0d_upd_drop", i), 32'(update_valid), 0);
      check($sformatf("vec%0d_tx_hold", i), 32'(tx_valid), 1);
      cycle(1'b0, 8'h00, 1'b1);
      check($sformatf("vec%0d_tx_done", i), 32'(tx_valid), 0);
      check($sformatf("vec%0d_err", i), 32'(frame_err_count), 32'(e0 + (vecs[i].resp == NAK ? 1 : 0)));
    end
    check("noun_after_naks", 32'(noun_data), 0);

    // Timeout after a partial frame, then a clean frame.
    e0 = int'(frame_err_count);
    cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h03, 1'b0); cycle(1'b1, 8'h00, 1'b0);
    repeat (TO - 1) cycle(1'b0, 8'h00, 1'b0);
    check("timeout_not_yet", 32'(frame_err_count), 32'(e0));
    cycle(1'b0, 8'h00, 1'b0);
    check("timeout_err", 32'(frame_err_count), 32'(e0 + 1));
    check("timeout_no_tx", 32'(tx_valid), 0);
    send_frame(40'hA5_03_01_02_00);
    check("post_timeout_apogee", 32'(apogee_data), 32'h0102);
    check("post_timeout_ack", 32'(tx_byte), 32'(ACK));
    cycle(1'b0, 8'h00, 1'b1);

    // A byte landing on the expiry cycle keeps the frame alive.
    e0 = int'(frame_err_count);
    cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h00, 1'b0);
    repeat (TO - 1) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 1'b0); cycle(1'b1, 8'h33, 1'b0); cycle(1'b1, 8'h33, 1'b0);
    check("byte_wins_ack", 32'(tx_byte), 32'(ACK));
    check("byte_wins_verb", 32'(verb_data), 32'h0033);
    check("byte_wins_err", 32'(frame_err_count), 32'(e0));
    cycle(1'b0, 8'h00, 1'b1);

    // Response stalled by tx_ready; a byte arriving meanwhile is dropped and counted.
    e0 = int'(frame_err_count);
    send_frame(40'hA5_01_12_34_27);
    for (int i = 0; i < 10; i++) begin
      cycle(i == 3, 8'h55, 1'b0);
      check("stall_tx_valid", 32'(tx_valid), 1);
      check("stall_tx_byte", 32'(tx_byte), 32'(ACK));
    end
    check("stall_err", 32'(frame_err_count), 32'(e0 + 1));
    check("stall_noun", 32'(noun_data), 32'h1234);
    cycle(1'b0, 8'h00, 1'b1);
    check("stall_release", 32'(tx_valid), 0);

    // Asynchronous reset in the middle of a frame.
    cycle(1'b1, 8'hA5, 1'b0); cycle(1'b1, 8'h00, 1'b0);
    #3 rx_valid = 1'b0; reset_n = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    send_frame(40'hA5_00_00_25_25);
    check("post_reset_verb", 32'(verb_data), 32'h0025);
    check("post_reset_ack", 32'(tx_byte), 32'(ACK));
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized traffic; -1 entries are forced idle cycles.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (q.size() == 0) begin
        kind = int'($urandom_range(0, 9));
        if (kind == 0) begin
          q.push_back(int'($urandom_range(0, 255)));
        end else if (kind == 1) begin
          q.push_back(8'hA5);
          for (int k = 0; k < int'($urandom_range(1, 3)); k++) q.push_back(int'($urandom_range(0, 255)));
          for (int k = 0; k < int'(TO) + 3; k++) q.push_back(-1);
        end else begin
          id = int'($urandom_range(0, 6));
          hi = int'($urandom_range(0, 255));
          if ($urandom_range(0, 7) != 0) hi = hi % 128;
          lo = ($urandom_range(0, 9) == 0) ? 8'hA5 : int'($urandom_range(0, 255));
          chk = id ^ hi ^ lo;
          if ($urandom_range(0, 4) == 0) chk = chk ^ 1;
          q.push_back(8'hA5); q.push_back(id); q.push_back(hi); q.push_back(lo); q.push_back(chk);
        end
      end
      tr = ($urandom_range(0, 2) != 0);
      if (q[0] == -1) begin
        void'(q.pop_front());
        cycle(1'b0, 8'h00, tr);
      end else if ($urandom_range(0, 3) != 0) begin
        b = q.pop_front();
        cycle(1'b1, 8'(b), tr);
      end else begin
        cycle(1'b0, 8'h00, tr);
      end
    end

    // Drain to idle, then saturate the error counter with dropped bytes.
    repeat (TO + 5) cycle(1'b0, 8'h00, 1'b1);
    send_frame(40'hA5_00_00_25_25);
    repeat (260) cycle(1'b1, 8'h5A, 1'b0);
    check("err_saturated", 32'(frame_err_count), 255);
    check("sat_tx_held", 32'(tx_valid), 1);
    cycle(1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
